// File: rtl/md_sched.sv
// Issue controller for the shared multiply/divide core: launches MD operations,
// keeps one operation in a single-entry buffer, and owns the HI/LO registers.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    input  logic [31:0] core_hi,
    input  logic [31:0] core_lo,
    output logic        core_start,
    output logic [3:0]  core_op,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       op_next, buf_op, buf_op_next;
    logic [31:0]      a_next, b_next, buf_a, buf_a_next, buf_b, buf_b_next;
    logic [31:0]      hi_next, lo_next;
    logic             buf_v, buf_v_next, start_next;
    logic             is_md, is_mv, accept, accept_md, launch_req, launch_buf;

    function automatic logic [CNT_W-1:0] latency(input logic [3:0] op);
        return (op == 4'd1 || op == 4'd2) ? MULT_CNT : DIV_CNT;
    endfunction

    assign is_md     = (req_op >= 4'd1) && (req_op <= 4'd4);
    assign is_mv     = (req_op >= 4'd5) && (req_op <= 4'd8);
    assign busy      = (state == RUN);
    assign stall     = req_valid && ((is_md && buf_v) || (is_mv && (busy || buf_v)));
    assign accept    = req_valid && !stall && !flush;
    assign accept_md = accept && is_md;
    assign rd_data   = (req_op == 4'd5) ? hi : ((req_op == 4'd6) ? lo : 32'd0);

    // On a commit edge with an empty buffer, an accepted MD request launches
    // directly so back-to-back issue never leaves an idle gap.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        op_next     = core_op;
        a_next      = core_a;
        b_next      = core_b;
        buf_v_next  = buf_v;
        buf_op_next = buf_op;
        buf_a_next  = buf_a;
        buf_b_next  = buf_b;
        hi_next     = hi;
        lo_next     = lo;
        start_next  = 1'b0;
        launch_req  = 1'b0;
        launch_buf  = 1'b0;

        case (state)
            IDLE: begin
                if (accept_md) launch_req = 1'b1;
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    hi_next = core_hi;
                    lo_next = core_lo;
                    if (buf_v && !flush) launch_buf = 1'b1;
                    else if (accept_md)  launch_req = 1'b1;
                    else                 state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                    if (accept_md) begin
                        buf_v_next  = 1'b1;
                        buf_op_next = req_op;
                        buf_a_next  = req_a;
                        buf_b_next  = req_b;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (launch_req) begin
            op_next    = req_op;
            a_next     = req_a;
            b_next     = req_b;
            cnt_next   = latency(req_op);
            state_next = RUN;
            start_next = 1'b1;
        end
        if (launch_buf) begin
            op_next    = buf_op;
            a_next     = buf_a;
            b_next     = buf_b;
            cnt_next   = latency(buf_op);
            state_next = RUN;
            start_next = 1'b1;
            buf_v_next = 1'b0;
        end
        if (flush) buf_v_next = 1'b0;

        // Moves to HI/LO are only accepted while idle, so they never race a commit.
        if (accept && req_op == 4'd7) hi_next = req_a;
        if (accept && req_op == 4'd8) lo_next = req_a;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            core_op    <= 4'd0;
            core_a     <= 32'd0;
            core_b     <= 32'd0;
            core_start <= 1'b0;
            buf_v      <= 1'b0;
            buf_op     <= 4'd0;
            buf_a      <= 32'd0;
            buf_b      <= 32'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            core_op    <= op_next;
            core_a     <= a_next;
            core_b     <= b_next;
            core_start <= start_next;
            buf_v      <= buf_v_next;
            buf_op     <= buf_op_next;
            buf_a      <= buf_a_next;
            buf_b      <= buf_b_next;
            hi         <= hi_next;
            lo         <= lo_next;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_md_sched;

    localparam int MULT_L = 5;
    localparam int DIV_L  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic        flush;
    logic [31:0] core_hi, core_lo;
    logic        core_start, busy, stall;
    logic [3:0]  core_op;
    logic [31:0] core_a, core_b, hi, lo, rd_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    md_req_t     m_q[$];
    bit          m_run, m_start, m_acc, exp_stall;
    int          m_left;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_hi, m_lo;

    always #5 clk = ~clk;

    md_sched #(.MULT_CYCLES(MULT_L), .DIV_CYCLES(DIV_L)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .core_hi(core_hi), .core_lo(core_lo), .core_start(core_start),
        .core_op(core_op), .core_a(core_a), .core_b(core_b), .busy(busy),
        .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    // Arithmetic the emulated core returns; {hi, lo}. Divide by zero yields {a, all ones}.
    function automatic logic [63:0] core_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: begin q = sa * sb; return q; end
            4'd2: return ua * ub;
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_start = 0; m_acc = 0; m_left = 0;
        m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_hi = 32'd0; m_lo = 32'd0;
        m_q.delete();
    endtask

    task automatic model_launch(input md_req_t r);
        m_op = r.op; m_a = r.a; m_b = r.b;
        m_left = (r.op == 4'd1 || r.op == 4'd2) ? MULT_L : DIV_L;
        m_run = 1;
        m_start = 1;
    endtask

    // Advances the reference model across one rising edge using the current inputs.
    task automatic model_step();
        md_req_t r, b;
        logic [63:0] res;
        bit md;
        md = req_op >= 4'd1 && req_op <= 4'd4;
        r.op = req_op; r.a = req_a; r.b = req_b;
        m_acc = req_valid && !exp_stall && !flush;
        m_start = 0;
        if (flush) m_q.delete();
        if (m_run) begin
            if (m_left == 1) begin
                res = core_result(m_op, m_a, m_b);
                m_hi = res[63:32];
                m_lo = res[31:0];
                if (m_q.size() > 0) begin
                    b = m_q.pop_front();
                    model_launch(b);
                end else if (m_acc && md) model_launch(r);
                else m_run = 0;
            end else begin
                m_left--;
                if (m_acc && md) m_q.push_back(r);
            end
        end else if (m_acc && md) model_launch(r);
        if (m_acc && req_op == 4'd7) m_hi = req_a;
        if (m_acc && req_op == 4'd8) m_lo = req_a;
    endtask

    task automatic checkOutput();
        logic [31:0] exp_rd;
        bit md, mv, bufd;
        md = req_op >= 4'd1 && req_op <= 4'd4;
        mv = req_op >= 4'd5 && req_op <= 4'd8;
        bufd = m_q.size() > 0;
        exp_stall = req_valid && ((md && bufd) || (mv && (m_run || bufd)));
        exp_rd = (req_op == 4'd5) ? m_hi : ((req_op == 4'd6) ? m_lo : 32'd0);
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("rd_data", rd_data, exp_rd);
        chk("busy", {31'd0, busy}, {31'd0, m_run});
        chk("core_start", {31'd0, core_start}, {31'd0, m_start});
        chk("core_op", {28'd0, core_op}, {28'd0, m_op});
        chk("core_a", core_a, m_a);
        chk("core_b", core_b, m_b);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle, step the model.
    task automatic applyStimulus(input bit v, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit f);
        logic [63:0] res;
        req_valid = v; req_op = op; req_a = a; req_b = b; flush = f;
        res = core_result(m_op, m_a, m_b);
        core_hi = res[63:32];
        core_lo = res[31:0];
        @(negedge clk);
        checkOutput();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 4'd0, 32'd0, 32'd0, 0);
    endtask

    // Holds a request until the model accepts it; returns the number of stalled cycles.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        bit done = 0;
        stalls = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            applyStimulus(1, op, a, b, 0);
            if (m_acc) done = 1;
            else stalls++;
        end
        if (!done) begin
            checks++;
            failures++;
            $error("[TB] FAIL issue_timeout observed=%0d expected=accept", stalls);
        end
    endtask

    initial begin
        int s;
        reset = 1; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; flush = 0;
        core_hi = 0; core_lo = 0;
        model_reset();
        #2;
        checkOutput();
        @(posedge clk);
        #1;
        reset = 0;

        // Signed mult of -1 by 2
        issue(4'd1, 32'hFFFF_FFFF, 32'd2, s);
        chk("mult_nostall", s, 0);
        idle(7);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFE);

        // div then mflo: stalls for the whole divide
        issue(4'd3, 32'd7, 32'd2, s);
        issue(4'd6, 32'd0, 32'd0, s);
        chk("mflo_stalls", s, DIV_L);
        chk("div_lo", lo, 32'd3);
        chk("div_hi", hi, 32'd1);
        idle(2);

        // mult, multu, div back to back
        issue(4'd1, 32'd3, 32'hFFFF_FFFD, s);
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
        chk("second_nostall", s, 0);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, s);
        chk("third_stalls", s, MULT_L - 1);
        idle(MULT_L + DIV_L + 2);

        // mthi while idle, mtlo while busy
        issue(4'd7, 32'h1234, 32'd0, s);
        chk("mthi", hi, 32'h1234);
        issue(4'd2, 32'd5, 32'd6, s);
        issue(4'd8, 32'hCAFE, 32'd0, s);
        chk("mtlo_stalls", s, MULT_L);
        chk("mtlo", lo, 32'hCAFE);

        // Flush drops the buffered divu
        issue(4'd1, 32'd9, 32'd9, s);
        issue(4'd4, 32'd100, 32'd0, s);
        applyStimulus(0, 4'd0, 32'd0, 32'd0, 1);
        idle(MULT_L + 3);
        chk("flush_lo", lo, 32'd81);

        // Async reset in the third busy cycle of a div
        issue(4'd7, 32'hAAAA_5555, 32'd0, s);
        issue(4'd4, 32'd50, 32'd7, s);
        idle(2);
        #2;
        reset = 1;
        #1;
        model_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_core_op", {28'd0, core_op}, 32'd0);
        @(posedge clk);
        #1;
        reset = 0;
        idle(DIV_L + 2);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 9)), a, b,
                          $urandom_range(0, 19) == 0);
        end
        idle(DIV_L * 2 + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
